fir_out_decimator: RTL
======================

# fir_out_decimator

Downstream post-processing stage for the 16-bit signed FIR output stream. It accepts one filtered sample per valid cycle and decimates by a runtime-selectable power of two using accumulate-and-dump averaging. Each averaged result is rounded, scaled and saturated to 8 bits, then buffered in a small FIFO behind a ready/valid output. The FIFO decouples the filter's constant sample rate from a slower consumer, such as a pin serializer or host readout.

## Interface
- `IN_W`, 16: input sample width, signed two's complement.
- `OUT_W`, 8: output sample width, signed.
- `DEPTH`, 4: FIFO depth in entries; must be a power of two, at least 2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` holds a new FIR sample this cycle.
- `in_data` in IN_W: signed FIR output sample.
- `dec_log2` in 2: decimation factor = 2^`dec_log2` (1, 2, 4 or 8).
- `shift` in 4: extra arithmetic right shift applied after averaging.
- `clear_ovf` in 1: clears `ovf` sticky flag.
- `out_valid` out 1: FIFO head is valid.
- `out_data` out OUT_W: FIFO head sample.
- `out_ready` in 1: consumer accepts head when high together with `out_valid`.
- `fifo_full` out 1: FIFO holds DEPTH entries.
- `ovf` out 1: sticky; a result was dropped because the FIFO was full.
- `sat` out 1: sticky; a result was saturated. Cleared by `clear_ovf`.

## Operation
- Accumulator: signed, IN_W+3 bits; cannot overflow for 8 samples.
- Sample counter `cnt`: 0..2^k−1.
- Active factor `k` is latched from `dec_log2` when `in_valid` is high and `cnt`==0 (frame start). A change to `dec_log2` mid-frame has no effect until the next frame.
- Frame start (`in_valid`, `cnt`==0): acc ← `in_data`. Otherwise acc ← acc + `in_data`.
- Dump occurs when `in_valid` is high and `cnt`==2^k−1. The full sum, including the current sample, goes to the result stage, and `cnt` wraps to 0.
- When k=0, every valid sample is a dump.
- Result stage: total shift s = k + `shift`, with `shift` sampled at the dump cycle.
  - If s>0: r = (sum + 2^(s−1)) >>> s, i.e. round half up, arithmetic shift.
  - If s=0: r = sum.
  - Saturate r to [−128, 127]; set `sat` if clamped.
- FIFO write: the result register pushes one entry.
  - If the FIFO is full and no pop occurs the same cycle, the result is dropped and `ovf` is set.
  - A simultaneous push and pop while full is accepted with no drop.
- FIFO read: a pop occurs when `out_valid` && `out_ready`. `out_data` shows the head and is stable while `out_valid` is high and `out_ready` is low.
- `clear_ovf` clears both `ovf` and `sat`. If a new ovf/sat event occurs in the same cycle, set wins.
- `in_valid` low: accumulator and counter hold.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `fifo_full`=0, `ovf`=0, `sat`=0. Internally: acc=0, `cnt`=0, k=0, result stage empty, FIFO empty.
- Reset asserted mid-frame discards the partial sum, the pending result and all FIFO contents.
- Latency: for a dump on the edge ending cycle t, the result register is valid in cycle t+1. The FIFO write occurs at the edge ending t+1, and `out_valid` is high in cycle t+2 if the FIFO was empty.
- Throughput: one input per cycle and one output per cycle with no bubbles, when `out_ready` is held high.
- `fifo_full` and `out_valid` are registered outputs derived from the FIFO count.

## Test plan
- k=0, `shift`=8, `in_data`=0x1234 each cycle, `out_ready`=1 → `out_data`=0x12 every cycle from cycle 2 onward; `sat`=0.
- Saturation: k=0, `shift`=0, inputs 0x7FFF then 0x8000 → outputs 0x7F then 0x80, `sat`=1. Pulsing `clear_ovf` clears `sat`.
- Averaging and rounding: `dec_log2`=2, `shift`=0, inputs 10, 20, 30, 41 → single output 25. Inputs −1, −1, −1, −3 → (−6+2)>>>2 = −1 (0xFF).
- Overflow: k=0, `out_ready`=0, 6 valid samples 1..6 (`shift`=0) → `fifo_full`=1 after 4 entries, `ovf`=1. Then `out_ready`=1 → outputs 1, 2, 3, 4 only.
- Config change mid-frame: `dec_log2`=2, two samples in, switch to 0 → the frame still completes after 4 samples, and subsequent samples each produce one output.
- Reset mid-frame, with 3 of 8 samples accumulated and 2 FIFO entries → `out_valid`=0 the next cycle. A fresh frame of 8 × 16 with `shift`=0 yields 16.

Source files
------------

// File: rtl/fir_out_decimator.sv
// Post-FIR decimator: accumulate-and-dump averaging by 2^k, round/shift/saturate
// to OUT_W bits, and a small FIFO feeding a ready/valid consumer.
module fir_out_decimator #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       dec_log2,
   input  logic [3:0]       shift,
   input  logic             clear_ovf,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   input  logic             out_ready,
   output logic             fifo_full,
   output logic             ovf,
   output logic             sat
);

   localparam int ACC_W = IN_W + 3;
   localparam int RND_W = ACC_W + 2;
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(-(2 ** (OUT_W - 1)));

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [1:0]              k_q, k_d;

   logic                    frameStart;
   logic [1:0]              kEff;
   logic [2:0]              lastCnt;
   logic                    dump;
   logic signed [ACC_W-1:0] sampleExt;
   logic signed [ACC_W-1:0] sumNow;

   logic [4:0]              shAmt;
   logic signed [RND_W-1:0] wideSum;
   logic signed [RND_W-1:0] half;
   logic signed [RND_W-1:0] rounded;
   logic                    clampHi, clampLo;
   logic [OUT_W-1:0]        satVal;
   logic                    satEvent;

   logic                    resValid_q, resValid_d;
   logic [OUT_W-1:0]        resData_q, resData_d;

   logic [OUT_W-1:0]        mem_q [DEPTH];
   logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
   logic [PTR_W:0]          count_q, count_d;
   logic                    outValid_q, full_q;
   logic                    ovf_q, ovf_d, sat_q, sat_d;
   logic                    isFull, pop, pushOk, drop;

   // The decimation factor is only taken from the input at a frame start, so
   // a mid-frame change waits for the next frame.
   always_comb begin
      frameStart = in_valid && (cnt_q == 3'd0);
      kEff       = frameStart ? dec_log2 : k_q;
      lastCnt    = (3'b001 << kEff) - 3'd1;
      dump       = in_valid && (cnt_q == lastCnt);
      sampleExt  = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
      sumNow     = frameStart ? sampleExt : acc_q + sampleExt;
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      k_d   = k_q;
      if (in_valid) begin
         acc_d = sumNow;
         k_d   = kEff;
         cnt_d = dump ? 3'd0 : cnt_q + 3'd1;
      end
   end

   // Round half up by adding 2^(s-1) before the arithmetic shift.
   always_comb begin
      shAmt    = {3'b000, kEff} + {1'b0, shift};
      wideSum  = {{(RND_W - ACC_W){sumNow[ACC_W-1]}}, sumNow};
      half     = (shAmt == 5'd0) ? '0 : (RND_W'(1) <<< (shAmt - 5'd1));
      rounded  = (wideSum + half) >>> shAmt;
      clampHi  = rounded > SAT_MAX;
      clampLo  = rounded < SAT_MIN;
      satVal   = clampHi ? SAT_MAX[OUT_W-1:0] :
                 clampLo ? SAT_MIN[OUT_W-1:0] : rounded[OUT_W-1:0];
      satEvent = dump && (clampHi || clampLo);
   end

   always_comb begin
      resValid_d = dump;
      resData_d  = dump ? satVal : resData_q;
   end

   // A push into a full FIFO still lands when the head pops in the same cycle.
   always_comb begin
      isFull  = (count_q == (PTR_W + 1)'(DEPTH));
      pop     = outValid_q && out_ready;
      pushOk  = resValid_q && (!isFull || pop);
      drop    = resValid_q && isFull && !pop;
      wrPtr_d = pushOk ? wrPtr_q + PTR_W'(1) : wrPtr_q;
      rdPtr_d = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
      count_d = count_q;
      if (pushOk && !pop) begin
         count_d = count_q + (PTR_W + 1)'(1);
      end else if (!pushOk && pop) begin
         count_d = count_q - (PTR_W + 1)'(1);
      end
   end

   // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
   always_comb begin
      ovf_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
      sat_d = satEvent ? 1'b1 : (clear_ovf ? 1'b0 : sat_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         k_q        <= '0;
         resValid_q <= 1'b0;
         resData_q  <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         outValid_q <= 1'b0;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         sat_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         resValid_q <= resValid_d;
         resData_q  <= resData_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         outValid_q <= (count_d != '0);
         full_q     <= (count_d == (PTR_W + 1)'(DEPTH));
         ovf_q      <= ovf_d;
         sat_q      <= sat_d;
         if (pushOk) begin
            mem_q[wrPtr_q] <= resData_q;
         end
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = mem_q[rdPtr_q];
   assign fifo_full = full_q;
   assign ovf       = ovf_q;
   assign sat       = sat_q;

endmodule
